// File: rtl/lut_pkg.sv
// Shared types and constants for the run-time programmable LUT function unit.
package lut_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } lut_state_e;

    localparam logic [15:0] LUT_DEFAULT_TABLE = 16'h00AA;

    function automatic int unsigned lut_depth(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/lut_shift_loader.sv
// Bit-serial table loader: bit counter, shadow register and terminal-count commit strobe.
module lut_shift_loader
    import lut_pkg::*;
#(
    parameter int unsigned N_IN = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic                       wr_bit,
    output logic [lut_depth(N_IN)-1:0] table_next,
    output logic                       commit
);

    localparam int unsigned DEPTH = lut_depth(N_IN);
    localparam logic [N_IN:0] LAST = (N_IN + 1)'(DEPTH - 1);
    localparam logic [N_IN:0] ONE  = (N_IN + 1)'(1);

    logic [N_IN:0]      cnt_q, cnt_d;
    logic [DEPTH-1:0]   shadow_q, shadow_d;

    always_comb begin
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        commit   = 1'b0;
        if (clear) begin
            cnt_d    = '0;
            shadow_d = '0;
        end else if (wr_en) begin
            shadow_d[cnt_q[N_IN-1:0]] = wr_bit;
            if (cnt_q == LAST) begin
                commit = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    // The final bit is merged here so the top can commit on the cycle it arrives.
    assign table_next = shadow_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

endmodule

// File: rtl/lut_function_unit.sv
// Registered N-input Boolean function unit with an atomically reloadable truth table
// and a saturating count of true results.
module lut_function_unit
    import lut_pkg::*;
#(
    parameter int unsigned                 N_IN          = 4,
    parameter logic [lut_depth(N_IN)-1:0]  DEFAULT_TABLE = (lut_depth(N_IN))'(LUT_DEFAULT_TABLE),
    parameter int unsigned                 CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  in_vec,
    output logic             in_ready,
    output logic             out_valid,
    output logic             y,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic [CNT_W-1:0] hit_count
);

    localparam int unsigned DEPTH = lut_depth(N_IN);

    lut_state_e         state_q, state_d;
    logic [DEPTH-1:0]   table_q, table_d;
    logic               y_q, y_d;
    logic               out_valid_q, out_valid_d;
    logic               cfg_done_q, cfg_done_d;
    logic [CNT_W-1:0]   hit_q, hit_d;

    logic               ld_wr_en;
    logic               ld_commit;
    logic [DEPTH-1:0]   ld_table;

    // A restart outranks a data bit arriving in the same cycle.
    assign ld_wr_en = (state_q == LOAD) && cfg_valid && !cfg_start;

    lut_shift_loader #(
        .N_IN (N_IN)
    ) u_loader (
        .clk        (clk),
        .reset      (reset),
        .clear      (cfg_start),
        .wr_en      (ld_wr_en),
        .wr_bit     (cfg_bit),
        .table_next (ld_table),
        .commit     (ld_commit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (cfg_start) state_d = LOAD;
            LOAD:    if (ld_commit) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        in_ready = (state_q == RUN);
        cfg_busy = (state_q == LOAD);
    end

    always_comb begin
        out_valid_d = in_valid && (state_q == RUN);
        y_d         = out_valid_d ? table_q[in_vec] : y_q;
        table_d     = ld_commit ? ld_table : table_q;
        cfg_done_d  = ld_commit;
        hit_d       = hit_q;
        if (out_valid_q && y_q && (hit_q != '1)) begin
            hit_d = hit_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            table_q     <= DEFAULT_TABLE;
            y_q         <= 1'b0;
            out_valid_q <= 1'b0;
            cfg_done_q  <= 1'b0;
            hit_q       <= '0;
        end else begin
            table_q     <= table_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            cfg_done_q  <= cfg_done_d;
            hit_q       <= hit_d;
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;
    assign cfg_done  = cfg_done_q;
    assign hit_count = hit_q;

endmodule
